// File: rtl/rgb_mixer_pkg.sv
// Shared definitions for the RGB fade sequencer: FSM encoding and register map.
package rgb_mixer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFade,
    StHold
  } state_e;

  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned CH_STRIDE = 3;
  localparam logic [3:0]  ADDR_HOLD = 4'd15;

  // Register address of preset p, channel c.
  function automatic logic [3:0] preset_addr(int unsigned p, int unsigned c);
    return 4'(p * CH_STRIDE + c);
  endfunction

endpackage

// File: rtl/rgb_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV cycles while run is high.
module rgb_tick_gen #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count 0..TICK_DIV-1, clearing whenever run drops.
  always_comb begin
    cnt_d = cnt_q;
    if (!run || cnt_q == CntMax) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Prescaler state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == CntMax);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Steps three PWM duty levels one unit per tick toward a preset colour, holds,
// then advances to the next preset.
module rgb_fade_sequencer
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NUM_PRESETS = 4,
  parameter int unsigned TICK_DIV    = 1000,
  localparam int unsigned IdxW       = $clog2(NUM_PRESETS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic [WIDTH-1:0] level0,
  output logic [WIDTH-1:0] level1,
  output logic [WIDTH-1:0] level2,
  output logic [IdxW-1:0]  seq_idx,
  output logic             busy,
  output logic             step_done
);

  logic [WIDTH-1:0] preset_q [NUM_PRESETS][NUM_CH];
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] hold_cnt_q;
  logic [WIDTH-1:0] level_q    [NUM_CH];
  logic [WIDTH-1:0] target     [NUM_CH];
  logic [WIDTH-1:0] level_step [NUM_CH];
  logic [IdxW-1:0]  seq_idx_q;
  logic             busy_q;
  logic             step_done_q;
  logic             at_target;
  logic             tick;
  state_e           state_q;

  rgb_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (enable),
    .tick    (tick)
  );

  // Configuration registers; unmapped addresses fall through every compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      for (int unsigned p = 0; p < NUM_PRESETS; p++) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          preset_q[p][c] <= '0;
        end
      end
    end else if (cfg_we) begin
      if (cfg_addr == ADDR_HOLD) begin
        hold_q <= cfg_wdata;
      end
      for (int unsigned p = 0; p < NUM_PRESETS; p++) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (cfg_addr == preset_addr(p, c)) begin
            preset_q[p][c] <= cfg_wdata;
          end
        end
      end
    end
  end

  // Live target lookup and saturating one-step move toward it.
  always_comb begin
    at_target = 1'b1;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      target[c]     = preset_q[seq_idx_q][c];
      level_step[c] = level_q[c];
      if (level_q[c] < target[c]) begin
        level_step[c] = level_q[c] + 1'b1;
      end else if (level_q[c] > target[c]) begin
        level_step[c] = level_q[c] - 1'b1;
      end
      if (level_q[c] != target[c]) begin
        at_target = 1'b0;
      end
    end
  end

  // Sequencer FSM with registered outputs; enable low overrides every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      seq_idx_q   <= '0;
      hold_cnt_q  <= '0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        level_q[c] <= '0;
      end
    end else begin
      step_done_q <= 1'b0;
      if (!enable) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StFade;
            busy_q  <= 1'b1;
          end
          StFade: begin
            if (at_target) begin
              state_q     <= StHold;
              busy_q      <= 1'b0;
              step_done_q <= 1'b1;
              hold_cnt_q  <= '0;
            end else if (tick) begin
              level_q <= level_step;
            end
          end
          StHold: begin
            // Compare before counting so a hold of 0 advances immediately.
            if (hold_cnt_q == hold_q) begin
              seq_idx_q <= seq_idx_q + 1'b1;
              state_q   <= StFade;
              busy_q    <= 1'b1;
            end else if (tick) begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign level0    = level_q[0];
  assign level1    = level_q[1];
  assign level2    = level_q[2];
  assign seq_idx   = seq_idx_q;
  assign busy      = busy_q;
  assign step_done = step_done_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with TICK_DIV=4.
module tb_rgb_fade_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] level0, level1, level2;
  logic [1:0] seq_idx;
  logic       busy, step_done;

  int n_checks = 0;
  int n_fail   = 0;

  rgb_fade_sequencer #(
    .WIDTH       (8),
    .NUM_PRESETS (4),
    .TICK_DIV    (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .level0    (level0),
    .level1    (level1),
    .level2    (level2),
    .seq_idx   (seq_idx),
    .busy      (busy),
    .step_done (step_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Negedges until step_done is seen; -1 if the budget runs out.
  task automatic run_until_step(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (step_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_until_level0(input int val, input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (level0 == 8'(val)) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int pulses;
    int seq_log [1:10];
    int sd_log  [1:10];

    // Reset state
    do_reset();
    check_eq("rst_level0", level0, 0);
    check_eq("rst_level1", level1, 0);
    check_eq("rst_level2", level2, 0);
    check_eq("rst_seq_idx", seq_idx, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_step_done", step_done, 0);

    // Basic fade to (3,0,1), hold 2
    cfg_write(4'd0, 8'd3);
    cfg_write(4'd1, 8'd0);
    cfg_write(4'd2, 8'd1);
    cfg_write(4'd15, 8'd2);
    enable = 1'b1;
    run_until_step(40, cyc);
    check_eq("t1_step_cycle", cyc, 13);
    check_eq("t1_level0", level0, 3);
    check_eq("t1_level1", level1, 0);
    check_eq("t1_level2", level2, 1);
    check_eq("t1_busy", busy, 0);
    @(negedge clk);
    check_eq("t1_pulse_once", step_done, 0);
    check_eq("t1_seq_in_hold", seq_idx, 0);
    cyc = -1;
    for (int i = 15; i <= 40; i++) begin
      @(negedge clk);
      if (seq_idx == 2'd1) begin
        cyc = i;
        break;
      end
    end
    check_eq("t1_hold_expire_cycle", cyc, 21);

    // Hold 0 advances immediately; fade between two presets
    do_reset();
    cfg_write(4'd0, 8'd2);
    cfg_write(4'd1, 8'd2);
    cfg_write(4'd2, 8'd2);
    cfg_write(4'd3, 8'd0);
    cfg_write(4'd4, 8'd5);
    cfg_write(4'd5, 8'd2);
    cfg_write(4'd15, 8'd0);
    enable = 1'b1;
    run_until_step(40, cyc);
    check_eq("t2_first_step", cyc, 9);
    @(negedge clk);
    check_eq("t2_seq_adv", seq_idx, 1);
    check_eq("t2_busy_again", busy, 1);
    repeat (6) @(negedge clk);
    check_eq("t2_mid_level0", level0, 0);
    check_eq("t2_mid_level1", level1, 4);
    check_eq("t2_mid_level2", level2, 2);
    run_until_step(40, cyc);
    check_eq("t2_second_step", cyc, 5);
    check_eq("t2_end_level0", level0, 0);
    check_eq("t2_end_level1", level1, 5);
    check_eq("t2_end_level2", level2, 2);

    // All presets zero, hold 0: seq_idx walks with a step_done per preset
    do_reset();
    enable = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      seq_log[i] = int'(seq_idx);
      sd_log[i]  = int'(step_done);
      pulses += int'(step_done);
    end
    check_eq("t3_pulses", pulses, 5);
    check_eq("t3_sd_at2", sd_log[2], 1);
    check_eq("t3_sd_at3", sd_log[3], 0);
    check_eq("t3_seq_at3", seq_log[3], 1);
    check_eq("t3_seq_at5", seq_log[5], 2);
    check_eq("t3_seq_at7", seq_log[7], 3);
    check_eq("t3_seq_at9", seq_log[9], 0);
    check_eq("t3_level0", level0, 0);

    // Freeze on enable low, resume on next tick
    do_reset();
    cfg_write(4'd0, 8'd200);
    enable = 1'b1;
    run_until_level0(50, 400, cyc);
    check_eq("t4_reach50_cycle", cyc, 200);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("t4_frozen", level0, 50);
    check_eq("t4_idle_busy", busy, 0);
    check_eq("t4_seq_kept", seq_idx, 0);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t4_before_tick", level0, 50);
    @(negedge clk);
    check_eq("t4_resume", level0, 51);

    // Retarget active preset mid-fade
    run_until_level0(60, 100, cyc);
    check_eq("t5_reach60_cycle", cyc, 36);
    cfg_we    = 1'b1;
    cfg_addr  = 4'd0;
    cfg_wdata = 8'd40;
    @(negedge clk);
    cfg_we = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t5_turnaround", level0, 59);
    run_until_step(200, cyc);
    check_eq("t5_step_cycle", cyc, 77);
    check_eq("t5_level0", level0, 40);

    // Asynchronous reset mid-fade (now fading toward preset1 = 0)
    repeat (6) @(negedge clk);
    check_eq("t6_pre_busy", busy, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_level0", level0, 0);
    check_eq("t6_rst_seq", seq_idx, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_step_done", step_done, 0);
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Unmapped addresses leave presets and hold untouched
    cfg_write(4'd12, 8'hAA);
    cfg_write(4'd13, 8'hAA);
    cfg_write(4'd14, 8'hAA);
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_unmapped_step", step_done, 1);
    @(negedge clk);
    check_eq("t6_unmapped_seq", seq_idx, 1);
    check_eq("t6_unmapped_level0", level0, 0);
    check_eq("t6_unmapped_level1", level1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_fade_sequencer.md
RGB_FADE_SEQUENCER -- requirements
Module: rgb_fade_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each colour level.
REQ-002 SHALL have parameter NUM_PRESETS, default 4, number of colour preset entries (power of two).
REQ-003 SHALL have parameter TICK_DIV, default 1000, clock cycles per fade/hold tick (minimum 2).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  run sequencer when high, freeze when low.
REQ-007 SHALL have port cfg_we  input  1  one-cycle register write strobe.
REQ-008 SHALL have port cfg_addr  input  4  register address: p*3+c is preset p, channel c; 15 is hold count; others ignored.
REQ-009 SHALL have port cfg_wdata  input  WIDTH  write data.
REQ-010 SHALL have ports level0, level1, level2  output  WIDTH each  current duty levels for the three PWM channels.
REQ-011 SHALL have port seq_idx  output  log2(NUM_PRESETS)  index of the active target preset.
REQ-012 SHALL have port busy  output  1  high in FADE.
REQ-013 SHALL have port step_done  output  1  one-cycle pulse when all levels reach target.

Function
REQ-014 SHALL implement FSM states IDLE, FADE, HOLD.
REQ-015 Tick: free-running prescaler counts 0..TICK_DIV-1 while enable is high and pulses tick when the count equals TICK_DIV-1; the prescaler clears whenever enable is low.
REQ-016 IDLE -> FADE on the first cycle enable is high; target is preset[seq_idx].
REQ-017 In FADE, on each tick, each level moves by exactly 1 toward its target channel value; a level equal to its target stays unchanged.
REQ-018 In FADE, when all three levels equal target (evaluated every cycle), the FSM SHALL go to HOLD, pulse step_done for one cycle, and clear the hold counter.
REQ-019 In HOLD, the hold counter increments per tick; when it equals the hold register, seq_idx increments modulo NUM_PRESETS and FSM returns to FADE.
REQ-020 Hold register 0 SHALL advance on the first cycle in HOLD, without waiting for a tick.
REQ-021 Target SHALL be read live from the preset registers; a write to the active preset during FADE takes effect on the next tick.
REQ-022 A write to the active preset during HOLD SHALL not re-enter FADE until the hold expires.
REQ-023 enable low in any state SHALL return the FSM to IDLE on the next cycle, freeze levels, keep seq_idx, and suppress step_done.
REQ-024 cfg_we with an unused address (12..14) SHALL have no effect; writes are accepted in every state with no back-pressure.
REQ-025 Level arithmetic SHALL never wrap: levels stay within 0..2^WIDTH-1.

Reset
REQ-026 reset_n low SHALL asynchronously clear levels, seq_idx, busy, step_done, presets, hold register, counters, and the FSM to IDLE.
REQ-027 Reset assertion mid-FADE SHALL take effect immediately without completing the step; release is synchronised to clk.

Structure
REQ-028 State encoding and the register address constants (ADDR_HOLD=15, channel stride 3) SHALL live in shared package rgb_mixer_pkg.
REQ-029 The prescaler SHALL be a sub-module rgb_tick_gen (parameter TICK_DIV; ports clk, reset_n, run, tick).
REQ-030 Outputs level0..2 SHALL be registered and connect directly to the existing PWM channels.

Verification (TICK_DIV=4)
REQ-031 Preset0=(3,0,1), hold=2, enable high -> levels reach (3,0,1) after 3 ticks (~12 cycles), step_done pulses once, busy falls.
REQ-032 Preset0=(2,2,2), preset1=(0,5,2), hold=0 -> HOLD advances immediately, seq_idx=1, level0 falls to 0 while level1 rises to 5, level2 stays 2.
REQ-033 NUM_PRESETS=4, all presets 0, hold=0 -> seq_idx walks 0,1,2,3,0 with step_done each step; levels stay 0.
REQ-034 Mid-FADE toward 200 at level 50, drop enable 10 cycles -> level frozen at 50; re-enable -> resumes at 51 on next tick.
REQ-035 Mid-FADE write active preset channel0 from 200 to 40 at level 60 -> level0 decrements to 40.
REQ-036 reset_n low mid-FADE -> all outputs 0 within the same cycle; cfg_addr=13 write -> no register changes.
